// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, status struct and helpers for the parametrised FIFO
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 16;
    localparam int FIFO_DEPTH_DEF  = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array; FIFO_FWFT_EN selects a combinational read port,
// otherwise the read port is registered and cleared by rst.
module fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{rst, rd_en};
    assign rd_data        = mem[rd_addr];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, count and flush;
// define FIFO_FWFT_EN for first-word fall-through read data.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     wr_ack,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] mem_rd_data;

    // Writes and reads are both suppressed in reset and flush cycles.
    assign wr_accept = wr_en && !full  && !flush && !rst;
    assign rd_accept = rd_en && !empty && !flush && !rst;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CNT_W'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem_rd_data;
`else
    assign data_out = mem_rd_data;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (both read modes)
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] data_in;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_out;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo_param #(
        .DATA_W (16),
        .DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .data_in      (data_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .wr_ack       (wr_ack),
        .overflow     (overflow),
        .underflow    (underflow),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        @(posedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_aempty", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_flags", 32'({wr_ack, overflow, underflow}), 0);

`ifndef FIFO_FWFT_EN
        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 16'(i));
            check("fill_ack", 32'(wr_ack), 1);
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= 7) ? 1 : 0);
            check("fill_full", 32'(full), (i == 8) ? 1 : 0);
            check("fill_aempty", 32'(almost_empty), (i <= 1) ? 1 : 0);
        end

        step(1'b1, 1'b0, 16'hBEEF);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_ack", 32'(wr_ack), 0);
        check("ovf_count", 32'(count), 8);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check("drain_data", 32'(data_out), 32'(i));
            check("drain_count", 32'(count), 32'(8 - i));
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_ovf_clr", 32'(overflow), 0);

        step(1'b0, 1'b1, 16'h0);
        check("udf_flag", 32'(underflow), 1);
        check("udf_hold", 32'(data_out), 32'h0008);

        step(1'b1, 1'b1, 16'h1234);
        check("wr_rd_empty_count", 32'(count), 1);
        check("wr_rd_empty_udf", 32'(underflow), 1);
        check("wr_rd_empty_ack", 32'(wr_ack), 1);
        check("wr_rd_empty_hold", 32'(data_out), 32'h0008);

        // Both accepted mid-range: count stays 1, oldest word pops
        step(1'b1, 1'b1, 16'h5678);
        check("wr_rd_mid_count", 32'(count), 1);
        check("wr_rd_mid_data", 32'(data_out), 32'h1234);
        step(1'b0, 1'b1, 16'h0);
        check("wr_rd_mid_tail", 32'(data_out), 32'h5678);
        check("wr_rd_mid_empty", 32'(empty), 1);

        // Wrap-around
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check("wrap_a_data", 32'(data_out), 32'h0100 + 32'(i));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0200 + 16'(i));
        check("wrap_count6", 32'(count), 6);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check("wrap_b_data", 32'(data_out), 32'h0200 + 32'(i));
        end
        check("wrap_count0", 32'(count), 0);

        // Flush with concurrent wr/rd
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0300 + 16'(i));
        check("pre_flush_count", 32'(count), 5);
        flush = 1'b1;
        step(1'b1, 1'b1, 16'hFFFF);
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_dout", 32'(data_out), 32'h0205);
        check("flush_flags", 32'({wr_ack, overflow, underflow}), 0);
        step(1'b1, 1'b0, 16'h00AA);
        step(1'b0, 1'b1, 16'h0);
        check("post_flush_data", 32'(data_out), 32'h00AA);

        // Simultaneous wr/rd while full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0030 + 16'(i));
        step(1'b1, 1'b1, 16'hDEAD);
        check("full_wr_rd_ovf", 32'(overflow), 1);
        check("full_wr_rd_count", 32'(count), 7);
        check("full_wr_rd_data", 32'(data_out), 32'h0030);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check("full_wr_rd_drain", 32'(data_out), 32'h0030 + 32'(i));
        end
        check("full_wr_rd_empty", 32'(empty), 1);

        // Reset mid-burst discards contents
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0040 + 16'(i));
        rst = 1'b1;
        step(1'b1, 1'b1, 16'h0099);
        check("midrst_count", 32'(count), 0);
        check("midrst_dout", 32'(data_out), 0);
        step(1'b1, 1'b0, 16'h0077);
        step(1'b0, 1'b1, 16'h0);
        check("midrst_data", 32'(data_out), 32'h0077);
        check("midrst_empty", 32'(empty), 1);
`else
        step(1'b1, 1'b0, 16'h0055);
        check("fwft_show", 32'(data_out), 32'h0055);
        check("fwft_count1", 32'(count), 1);
        step(1'b0, 1'b1, 16'h0);
        check("fwft_pop_empty", 32'(empty), 1);
        check("fwft_pop_zero", 32'(data_out), 0);
        step(1'b1, 1'b0, 16'h0011);
        step(1'b1, 1'b0, 16'h0022);
        check("fwft_head", 32'(data_out), 32'h0011);
        step(1'b0, 1'b1, 16'h0);
        check("fwft_next", 32'(data_out), 32'h0022);
        step(1'b0, 1'b1, 16'h0);
        check("fwft_drained", 32'(data_out), 0);
        step(1'b0, 1'b1, 16'h0);
        check("fwft_udf", 32'(underflow), 1);
        check("fwft_udf_zero", 32'(data_out), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
